hex2ascii_stream: RTL

Parametrised hex-word-to-ASCII serializer. Accepts one NIBBLES-digit word over a valid/ready handshake. Emits its hex digits as 7-bit ASCII characters, one per handshake, most significant digit first. Adds selectable letter case and leading-zero suppression, and feeds the console/UART transmit path in place of per-digit lookup.

---
 rtl/hex2ascii_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hex2ascii_stream.sv
// Serialises a NIBBLES-digit hex word into 7-bit ASCII characters,
// most significant digit first, with letter-case and zero-suppression modes.
module hex2ascii_stream #(
    parameter int NIBBLES = 8,
    parameter int CNT_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic [1:0]             case_sel,
    input  logic                   suppress,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_char,
    output logic                   out_last
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t               state_q, state_d;
    logic [4*NIBBLES-1:0] word_q, word_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [1:0]           case_q, case_d;
    logic                 valid_q, valid_d;
    logic [6:0]           char_q, char_d;
    logic                 last_q, last_d;
    logic                 ready_q, ready_d;

    logic [CNT_W-1:0]     start_idx;
    logic [CNT_W-1:0]     next_idx;

    function automatic logic [3:0] nib_at(
        input logic [4*NIBBLES-1:0] w,
        input logic [CNT_W-1:0]     i
    );
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (CNT_W'(k) == i) begin
                n = w[4*k +: 4];
            end
        end
        return n;
    endfunction

    // Mixed case keeps b and d lowercase so they stay distinct from 8 and 0
    function automatic logic [6:0] to_ascii(
        input logic [3:0] n,
        input logic [1:0] cs
    );
        logic lower;
        if (n < 4'd10) begin
            return 7'h30 + {3'b000, n};
        end
        lower = (cs == 2'd2) ||
                ((cs == 2'd0) && ((n == 4'hB) || (n == 4'hD)));
        return (lower ? 7'h61 : 7'h41) + {3'b000, n - 4'd10};
    endfunction

    always_comb begin
        start_idx = CNT_W'(NIBBLES - 1);
        if (suppress) begin
            start_idx = '0;
            for (int k = 0; k < NIBBLES; k++) begin
                if (in_data[4*k +: 4] != 4'h0) begin
                    start_idx = CNT_W'(k);
                end
            end
        end
    end

    assign next_idx = idx_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case_d  = case_q;
        valid_d = valid_q;
        char_d  = char_q;
        last_d  = last_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    word_d  = in_data;
                    case_d  = case_sel;
                    idx_d   = start_idx;
                    char_d  = to_ascii(nib_at(in_data, start_idx), case_sel);
                    valid_d = 1'b1;
                    last_d  = (start_idx == '0);
                    ready_d = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = next_idx;
                        char_d = to_ascii(nib_at(word_q, next_idx), case_q);
                        last_d = (next_idx == '0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            case_q  <= '0;
            valid_q <= 1'b0;
            char_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            case_q  <= case_d;
            valid_q <= valid_d;
            char_q  <= char_d;
            last_q  <= last_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_char  = char_q;
    assign out_last  = last_q;

endmodule
